// File: rtl/muldiv_ctrl_if.sv
// Execute-stage HI/LO op bus plus the multiplier and divider IP connections.
// The controller takes the slave view; the pipeline/IP side takes the master view.
interface muldiv_ctrl_if;
  logic        op_valid;
  logic [2:0]  op;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic        flush;
  logic        ex_stall_in;
  logic        stall;
  logic [31:0] hi;
  logic [31:0] lo;
  logic [32:0] mul_a;
  logic [32:0] mul_b;
  logic [65:0] mul_p;
  logic        div_valid;
  logic        div_ready;
  logic [31:0] div_dividend;
  logic [31:0] div_divisor;
  logic        div_signed;
  logic        div_dout_valid;
  logic [31:0] div_quot;
  logic [31:0] div_rem;

  modport master (
    output op_valid, op, src_a, src_b, flush, ex_stall_in,
           mul_p, div_ready, div_dout_valid, div_quot, div_rem,
    input  stall, hi, lo, mul_a, mul_b,
           div_valid, div_dividend, div_divisor, div_signed
  );

  modport slave (
    input  op_valid, op, src_a, src_b, flush, ex_stall_in,
           mul_p, div_ready, div_dout_valid, div_quot, div_rem,
    output stall, hi, lo, mul_a, mul_b,
           div_valid, div_dividend, div_divisor, div_signed
  );
endinterface

// File: rtl/muldiv_ctrl.sv
// Multi-cycle HI/LO controller: sequences a fixed-latency multiplier and a
// valid/ready divider, owns HI/LO and stalls exe until each result commits.
module muldiv_ctrl #(
  parameter int MUL_LAT = 2
) (
  input logic          clk,
  input logic          rst,
  muldiv_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE,
    MUL_WAIT,
    DIV_ISSUE,
    DIV_WAIT,
    DIV_DRAIN,
    DONE
  } state_t;

  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;
  localparam logic [3:0] MUL_CNT  = 4'(MUL_LAT);

  state_t      state;
  state_t      next_state;
  state_t      after_commit;
  logic [3:0]  cnt;
  logic [31:0] hi_q;
  logic [31:0] lo_q;
  logic [31:0] hi_d;
  logic [31:0] lo_d;
  logic        hi_we;
  logic        lo_we;
  logic        latch_mul;
  logic        latch_div;
  logic        stall_raw;
  logic [32:0] mul_a_q;
  logic [32:0] mul_b_q;
  logic [31:0] dividend_q;
  logic [31:0] divisor_q;
  logic        div_signed_q;
  logic        div_req;
  logic        handshake;
  logic        is_mul;
  logic        is_div;
  logic        legal_op;
  logic        accept;
  logic        unused_mul_p;

  assign is_mul       = (bus.op == OP_MULT) || (bus.op == OP_MULTU);
  assign is_div       = (bus.op == OP_DIV) || (bus.op == OP_DIVU);
  assign legal_op     = is_mul || is_div || (bus.op == OP_MTHI) || (bus.op == OP_MTLO);
  assign accept       = bus.op_valid && !bus.flush && legal_op;
  assign div_req      = (state == DIV_ISSUE);
  assign handshake    = div_req && bus.div_ready;
  assign after_commit = bus.ex_stall_in ? DONE : IDLE;
  assign unused_mul_p = &{1'b0, bus.mul_p[65:64]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    stall_raw  = 1'b0;
    hi_we      = 1'b0;
    lo_we      = 1'b0;
    hi_d       = 32'd0;
    lo_d       = 32'd0;
    latch_mul  = 1'b0;
    latch_div  = 1'b0;
    unique case (state)
      IDLE: begin
        if (accept) begin
          if (is_mul) begin
            latch_mul  = 1'b1;
            stall_raw  = 1'b1;
            next_state = MUL_WAIT;
          end else if (is_div && (bus.src_b != 32'd0)) begin
            latch_div  = 1'b1;
            stall_raw  = 1'b1;
            next_state = DIV_ISSUE;
          end else begin
            // Divide-by-zero, MTHI and MTLO all finish in the accept cycle.
            hi_we      = is_div || (bus.op == OP_MTHI);
            lo_we      = is_div || (bus.op == OP_MTLO);
            hi_d       = bus.src_a;
            lo_d       = is_div ? 32'hFFFF_FFFF : bus.src_a;
            next_state = after_commit;
          end
        end
      end
      MUL_WAIT: begin
        if (bus.flush) begin
          next_state = IDLE;
        end else if (cnt == 4'd1) begin
          hi_we      = 1'b1;
          lo_we      = 1'b1;
          hi_d       = bus.mul_p[63:32];
          lo_d       = bus.mul_p[31:0];
          next_state = after_commit;
        end else begin
          stall_raw = 1'b1;
        end
      end
      DIV_ISSUE: begin
        stall_raw = 1'b1;
        // A divide the IP has already taken must be drained even when flushed.
        if (handshake) begin
          next_state = bus.flush ? DIV_DRAIN : DIV_WAIT;
        end else if (bus.flush) begin
          next_state = IDLE;
        end
      end
      DIV_WAIT: begin
        if (bus.flush) begin
          next_state = bus.div_dout_valid ? IDLE : DIV_DRAIN;
        end else if (bus.div_dout_valid) begin
          hi_we      = 1'b1;
          lo_we      = 1'b1;
          hi_d       = bus.div_rem;
          lo_d       = bus.div_quot;
          next_state = after_commit;
        end else begin
          stall_raw = 1'b1;
        end
      end
      DIV_DRAIN: begin
        stall_raw = bus.op_valid;
        if (bus.div_dout_valid) begin
          next_state = IDLE;
        end
      end
      DONE: begin
        if (bus.flush || !bus.ex_stall_in) begin
          next_state = IDLE;
        end
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hi_q         <= 32'd0;
      lo_q         <= 32'd0;
      cnt          <= 4'd0;
      mul_a_q      <= 33'd0;
      mul_b_q      <= 33'd0;
      dividend_q   <= 32'd0;
      divisor_q    <= 32'd0;
      div_signed_q <= 1'b0;
    end else begin
      if (hi_we) begin
        hi_q <= hi_d;
      end
      if (lo_we) begin
        lo_q <= lo_d;
      end
      if (latch_mul) begin
        cnt     <= MUL_CNT;
        mul_a_q <= (bus.op == OP_MULT) ? {bus.src_a[31], bus.src_a} : {1'b0, bus.src_a};
        mul_b_q <= (bus.op == OP_MULT) ? {bus.src_b[31], bus.src_b} : {1'b0, bus.src_b};
      end else if ((state == MUL_WAIT) && (cnt != 4'd0)) begin
        cnt <= cnt - 4'd1;
      end
      if (latch_div) begin
        dividend_q   <= bus.src_a;
        divisor_q    <= bus.src_b;
        div_signed_q <= (bus.op == OP_DIV);
      end
    end
  end

  assign bus.stall        = stall_raw && !bus.flush && !rst;
  assign bus.hi           = hi_q;
  assign bus.lo           = lo_q;
  assign bus.mul_a        = mul_a_q;
  assign bus.mul_b        = mul_b_q;
  assign bus.div_valid    = div_req;
  assign bus.div_dividend = dividend_q;
  assign bus.div_divisor  = divisor_q;
  assign bus.div_signed   = div_signed_q;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Bench for muldiv_ctrl: directed scenarios plus random ops checked against
// an arithmetic HI/LO model; the multiplier and divider IPs are modelled here.
module tb_muldiv_ctrl;

  localparam int MUL_LAT = 2;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  logic [31:0] ref_hi;
  logic [31:0] ref_lo;
  logic signed [65:0] mul_stage;

  muldiv_ctrl_if bus ();

  muldiv_ctrl #(.MUL_LAT(MUL_LAT)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  always #5 clk = ~clk;

  // One register stage after the operand latch gives a product MUL_LAT=2 cycles after acceptance.
  always @(posedge clk) begin
    mul_stage <= $signed(bus.mul_a) * $signed(bus.mul_b);
  end
  assign bus.mul_p = mul_stage;

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic v, input logic [2:0] o, input logic [31:0] a,
                               input logic [31:0] b, input logic fl, input logic es);
    bus.op_valid    = v;
    bus.op          = o;
    bus.src_a       = a;
    bus.src_b       = b;
    bus.flush       = fl;
    bus.ex_stall_in = es;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Runs one op with ex_stall_in=0 until stall drops, then checks stall length and HI/LO.
  task automatic doOp(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                      input int rdy_dly, input int div_lat);
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
    logic signed [63:0] sp;
    logic [63:0] up;
    int   exp_stall;
    int   stall_cycles;
    int   issue_cnt;
    int   wait_cnt;
    logic div_busy;
    logic stall_now;
    logic hs;
    logic done;
    logic saw_valid;
    logic exp_req;
    exp_hi    = ref_hi;
    exp_lo    = ref_lo;
    exp_stall = 0;
    exp_req   = 1'b0;
    case (o)
      3'd1: begin
        sp = $signed(a) * $signed(b);
        {exp_hi, exp_lo} = sp;
        exp_stall = MUL_LAT;
      end
      3'd2: begin
        up = {32'd0, a} * {32'd0, b};
        {exp_hi, exp_lo} = up;
        exp_stall = MUL_LAT;
      end
      3'd3, 3'd4: begin
        if (b == 32'd0) begin
          exp_hi = a;
          exp_lo = 32'hFFFF_FFFF;
        end else begin
          if (o == 3'd3) begin
            exp_lo = $signed(a) / $signed(b);
            exp_hi = $signed(a) % $signed(b);
          end else begin
            exp_lo = a / b;
            exp_hi = a % b;
          end
          exp_stall = rdy_dly + div_lat + 1;
          exp_req   = 1'b1;
        end
      end
      3'd5: exp_hi = a;
      3'd6: exp_lo = a;
      default: ;
    endcase
    stall_cycles = 0;
    issue_cnt    = 0;
    wait_cnt     = 0;
    div_busy     = 1'b0;
    done         = 1'b0;
    saw_valid    = 1'b0;
    applyStimulus(1'b1, o, a, b, 1'b0, 1'b0);
    for (int cyc = 0; cyc < 100; cyc++) begin
      bus.div_ready      = 1'b0;
      bus.div_dout_valid = 1'b0;
      if (bus.div_valid) begin
        saw_valid     = 1'b1;
        bus.div_ready = (issue_cnt == rdy_dly);
        issue_cnt++;
      end
      if (div_busy) begin
        wait_cnt++;
        if (wait_cnt == div_lat) begin
          bus.div_dout_valid = 1'b1;
          div_busy           = 1'b0;
          if (bus.div_signed) begin
            bus.div_quot = $signed(bus.div_dividend) / $signed(bus.div_divisor);
            bus.div_rem  = $signed(bus.div_dividend) % $signed(bus.div_divisor);
          end else begin
            bus.div_quot = bus.div_dividend / bus.div_divisor;
            bus.div_rem  = bus.div_dividend % bus.div_divisor;
          end
        end
      end
      @(negedge clk);
      stall_now = bus.stall;
      hs        = bus.div_valid && bus.div_ready;
      nextCycle();
      if (hs) begin
        div_busy = 1'b1;
        wait_cnt = 0;
      end
      if (!stall_now) begin
        done = 1'b1;
        break;
      end
      stall_cycles++;
    end
    bus.div_ready      = 1'b0;
    bus.div_dout_valid = 1'b0;
    applyStimulus(1'b0, 3'd0, 32'd0, 32'd0, 1'b0, 1'b0);
    checkOutput("op_done", 64'(done), 64'd1);
    checkOutput("stall_cycles", 64'(stall_cycles), 64'(exp_stall));
    checkOutput("div_request", 64'(saw_valid), 64'(exp_req));
    checkOutput("hi", 64'(bus.hi), 64'(exp_hi));
    checkOutput("lo", 64'(bus.lo), 64'(exp_lo));
    ref_hi = exp_hi;
    ref_lo = exp_lo;
  endtask

  initial begin
    logic [2:0]  r_op;
    logic [31:0] r_a;
    logic [31:0] r_b;
    checks             = 0;
    errors             = 0;
    clk                = 1'b0;
    rst                = 1'b1;
    ref_hi             = 32'd0;
    ref_lo             = 32'd0;
    bus.div_ready      = 1'b0;
    bus.div_dout_valid = 1'b0;
    bus.div_quot       = 32'd0;
    bus.div_rem        = 32'd0;
    applyStimulus(1'b0, 3'd0, 32'd0, 32'd0, 1'b0, 1'b0);
    #1;
    checkOutput("rst_hi", 64'(bus.hi), 64'd0);
    checkOutput("rst_lo", 64'(bus.lo), 64'd0);
    checkOutput("rst_stall", 64'(bus.stall), 64'd0);
    checkOutput("rst_div_valid", 64'(bus.div_valid), 64'd0);
    checkOutput("rst_mul_a", 64'(bus.mul_a), 64'd0);
    checkOutput("rst_mul_b", 64'(bus.mul_b), 64'd0);
    checkOutput("rst_dividend", 64'(bus.div_dividend), 64'd0);
    checkOutput("rst_divisor", 64'(bus.div_divisor), 64'd0);
    checkOutput("rst_div_signed", 64'(bus.div_signed), 64'd0);
    repeat (2) nextCycle();
    rst = 1'b0;
    nextCycle();

    $display("[TB] directed multiply and divide");
    doOp(3'd1, 32'hFFFF_FFFE, 32'd3, 0, 0);
    checkOutput("mult_hi_const", 64'(bus.hi), 64'hFFFF_FFFF);
    checkOutput("mult_lo_const", 64'(bus.lo), 64'hFFFF_FFFA);
    checkOutput("mult_mul_a", 64'(bus.mul_a), 64'h1_FFFF_FFFE);
    doOp(3'd2, 32'hFFFF_FFFE, 32'd3, 0, 0);
    checkOutput("multu_hi_const", 64'(bus.hi), 64'h0000_0002);
    checkOutput("multu_mul_a", 64'(bus.mul_a), 64'h0_FFFF_FFFE);
    doOp(3'd3, 32'hFFFF_FFF9, 32'd2, 1, 10);
    checkOutput("div_lo_const", 64'(bus.lo), 64'hFFFF_FFFD);
    checkOutput("div_hi_const", 64'(bus.hi), 64'hFFFF_FFFF);
    doOp(3'd4, 32'h0000_1234, 32'd0, 0, 0);
    checkOutput("divz_hi_const", 64'(bus.hi), 64'h0000_1234);

    $display("[TB] flush in DIV_WAIT then MTHI");
    applyStimulus(1'b1, 3'd3, 32'd100, 32'd7, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("drain_accept_stall", 64'(bus.stall), 64'd1);
    nextCycle();
    bus.div_ready = 1'b1;
    @(negedge clk);
    checkOutput("drain_issue_valid", 64'(bus.div_valid), 64'd1);
    nextCycle();
    bus.div_ready = 1'b0;
    bus.flush     = 1'b1;
    @(negedge clk);
    checkOutput("flush_stall", 64'(bus.stall), 64'd0);
    nextCycle();
    applyStimulus(1'b1, 3'd5, 32'h0000_00AA, 32'd0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("drain_hold_stall", 64'(bus.stall), 64'd1);
      nextCycle();
    end
    bus.div_dout_valid = 1'b1;
    bus.div_quot       = 32'h1111_1111;
    bus.div_rem        = 32'h2222_2222;
    @(negedge clk);
    checkOutput("drain_strobe_stall", 64'(bus.stall), 64'd1);
    nextCycle();
    bus.div_dout_valid = 1'b0;
    checkOutput("drain_hi_kept", 64'(bus.hi), 64'h0000_1234);
    checkOutput("drain_lo_kept", 64'(bus.lo), 64'hFFFF_FFFF);
    @(negedge clk);
    checkOutput("mthi_stall", 64'(bus.stall), 64'd0);
    nextCycle();
    applyStimulus(1'b0, 3'd0, 32'd0, 32'd0, 1'b0, 1'b0);
    checkOutput("mthi_hi", 64'(bus.hi), 64'h0000_00AA);
    checkOutput("mthi_lo", 64'(bus.lo), 64'hFFFF_FFFF);

    $display("[TB] MTLO held by ex_stall_in");
    applyStimulus(1'b1, 3'd6, 32'h0000_0055, 32'd0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("mtlo_hold_stall", 64'(bus.stall), 64'd0);
      nextCycle();
      checkOutput("mtlo_lo", 64'(bus.lo), 64'h0000_0055);
    end
    bus.ex_stall_in = 1'b0;
    nextCycle();
    applyStimulus(1'b1, 3'd5, 32'h0000_0077, 32'd0, 1'b0, 1'b0);
    nextCycle();
    applyStimulus(1'b0, 3'd0, 32'd0, 32'd0, 1'b0, 1'b0);
    checkOutput("after_done_mthi", 64'(bus.hi), 64'h0000_0077);

    $display("[TB] flush on the multiply commit cycle");
    applyStimulus(1'b1, 3'd1, 32'd5, 32'd7, 1'b0, 1'b0);
    nextCycle();
    nextCycle();
    bus.flush = 1'b1;
    @(negedge clk);
    checkOutput("mul_flush_stall", 64'(bus.stall), 64'd0);
    nextCycle();
    applyStimulus(1'b0, 3'd0, 32'd0, 32'd0, 1'b0, 1'b0);
    nextCycle();
    checkOutput("mul_flush_hi", 64'(bus.hi), 64'h0000_0077);
    checkOutput("mul_flush_lo", 64'(bus.lo), 64'h0000_0055);

    $display("[TB] multiply held in DONE");
    applyStimulus(1'b1, 3'd1, 32'd6, 32'd7, 1'b0, 1'b1);
    nextCycle();
    nextCycle();
    @(negedge clk);
    checkOutput("held_commit_stall", 64'(bus.stall), 64'd0);
    nextCycle();
    checkOutput("held_lo", 64'(bus.lo), 64'd42);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checkOutput("held_done_stall", 64'(bus.stall), 64'd0);
      nextCycle();
    end
    bus.ex_stall_in = 1'b0;
    nextCycle();
    applyStimulus(1'b0, 3'd0, 32'd0, 32'd0, 1'b0, 1'b0);
    checkOutput("held_hi", 64'(bus.hi), 64'd0);

    $display("[TB] reset during MUL_WAIT");
    applyStimulus(1'b1, 3'd1, 32'd9, 32'd9, 1'b0, 1'b0);
    nextCycle();
    #2;
    rst = 1'b1;
    #1;
    checkOutput("midrst_lo", 64'(bus.lo), 64'd0);
    checkOutput("midrst_stall", 64'(bus.stall), 64'd0);
    checkOutput("midrst_mul_a", 64'(bus.mul_a), 64'd0);
    bus.div_dout_valid = 1'b1;
    bus.div_quot       = 32'h0BAD_0001;
    bus.div_rem        = 32'h0BAD_0002;
    nextCycle();
    rst = 1'b0;
    applyStimulus(1'b0, 3'd0, 32'd0, 32'd0, 1'b0, 1'b0);
    nextCycle();
    bus.div_dout_valid = 1'b0;
    checkOutput("late_strobe_hi", 64'(bus.hi), 64'd0);
    checkOutput("late_strobe_lo", 64'(bus.lo), 64'd0);
    ref_hi = 32'd0;
    ref_lo = 32'd0;
    doOp(3'd1, 32'hFFFF_FFFE, 32'd3, 0, 0);

    $display("[TB] random ops");
    for (int n = 0; n < 40; n++) begin
      r_op = 3'($urandom_range(7, 0));
      r_a  = $urandom;
      r_b  = ($urandom_range(3, 0) == 0) ? 32'd0 : $urandom;
      if ($urandom_range(1, 0) == 1) begin
        r_a = r_a >> $urandom_range(31, 0);
      end
      if ((r_op == 3'd3) && (r_a == 32'h8000_0000) && (r_b == 32'hFFFF_FFFF)) begin
        r_b = 32'd1;
      end
      doOp(r_op, r_a, r_b, $urandom_range(3, 0), $urandom_range(6, 1));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
